// File: rtl/calc_key_sequencer_if.sv
// Keypad-to-calculator link: key select pulses and mode flag in,
// display value and status flags out.
interface calc_key_sequencer_if #(
   parameter int W = 16
);
   logic          key_strobe;
   logic [4:0]    key_val;
   logic          dec_mode;
   logic [W-1:0]  display_val;
   logic [1:0]    state;
   logic [2:0]    op_sel;
   logic [2:0]    digit_cnt;
   logic          overflow;
   logic          negative;
   logic          result_pulse;

   // Keypad / test side: issues keys, observes the calculator.
   modport master (
      output key_strobe, key_val, dec_mode,
      input  display_val, state, op_sel, digit_cnt, overflow, negative, result_pulse
   );

   // Calculator side: consumes keys, drives display and flags.
   modport slave (
      input  key_strobe, key_val, dec_mode,
      output display_val, state, op_sel, digit_cnt, overflow, negative, result_pulse
   );
endinterface

// File: rtl/calc_key_sequencer.sv
// Two-operand calculator sequencer driven by keypad select pulses.
// Builds operand A, operator and operand B, executes on EXE (or chains on a
// new operator) and presents the value to render plus status flags. All
// outputs are registered, so every key shows its effect one cycle later.
module calc_key_sequencer #(
   parameter int W          = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   calc_key_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'd0,
      ST_OP_SET  = 2'd1,
      ST_ENTER_B = 2'd2,
      ST_RESULT  = 2'd3
   } state_e;

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;

   localparam logic [4:0] KEY_ADD = 5'h10;
   localparam logic [4:0] KEY_MUL = 5'h11;
   localparam logic [4:0] KEY_AND = 5'h12;
   localparam logic [4:0] KEY_EXE = 5'h13;
   localparam logic [4:0] KEY_SUB = 5'h14;
   localparam logic [4:0] KEY_OR  = 5'h15;
   localparam logic [4:0] KEY_CE  = 5'h16;
   localparam logic [4:0] KEY_CLR = 5'h17;

   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

   // Map an operator key code to its op_sel encoding; non-operators give OP_NONE.
   function automatic logic [2:0] key_to_op(input logic [4:0] key);
      logic [2:0] op;
      case (key)
         KEY_ADD: op = OP_ADD;
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         KEY_AND: op = OP_AND;
         KEY_OR:  op = OP_OR;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

   // Append one digit to an operand: v*10+d or v*16+d, truncated to W bits.
   function automatic logic [W-1:0] shift_in(input logic [W-1:0] v,
                                             input logic [3:0]   d,
                                             input logic         dec);
      logic [W-1:0] dz;
      logic [W-1:0] r;
      dz = {{(W-4){1'b0}}, d};
      if (dec) begin
         r = {v[W-4:0], 3'b000} + {v[W-2:0], 1'b0} + dz;
      end else begin
         r = {v[W-5:0], 4'h0} + dz;
      end
      return r;
   endfunction

   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  res_q, res_d;
   logic [W-1:0]  disp_q, disp_d;
   logic [2:0]    op_q, op_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [2:0]    cnt_a_q, cnt_a_d;   // digits belonging to A, restored on CE in OP_SET
   logic          ovf_q, ovf_d;
   logic          neg_q, neg_d;
   logic          pulse_q, pulse_d;
   logic          dec_q;
   logic          mode_vld_q;         // dec_q holds a real sample (no edge right after reset)

   logic          mode_edge_s;
   logic          clr_s;
   logic          key_is_digit_s;
   logic          digit_ok_s;
   logic [3:0]    digit_s;
   logic [2:0]    key_op_s;
   logic [W-1:0]  digit_w_s;

   logic [W:0]     sum_s;
   logic [2*W-1:0] prod_s;
   logic [W-1:0]   alu_res_s;
   logic           alu_ovf_s;
   logic           alu_neg_s;

   assign mode_edge_s    = mode_vld_q && (bus.dec_mode != dec_q);
   assign key_is_digit_s = ~bus.key_val[4];
   assign digit_s        = bus.key_val[3:0];
   assign digit_ok_s     = key_is_digit_s && !(bus.dec_mode && (digit_s > 4'd9));
   assign key_op_s       = key_to_op(bus.key_val);
   assign digit_w_s      = {{(W-4){1'b0}}, digit_s};

   // Evaluate A op B with the flags the operation produces.
   always_comb begin
      sum_s     = {1'b0, a_q} + {1'b0, b_q};
      prod_s    = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
      alu_res_s = a_q;
      alu_ovf_s = 1'b0;
      alu_neg_s = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res_s = sum_s[W-1:0];
            alu_ovf_s = sum_s[W];
         end
         OP_SUB: begin
            alu_res_s = a_q - b_q;
            alu_neg_s = (a_q < b_q);
         end
         OP_MUL: begin
            alu_res_s = prod_s[W-1:0];
            alu_ovf_s = |prod_s[2*W-1:W];
         end
         OP_AND:  alu_res_s = a_q & b_q;
         OP_OR:   alu_res_s = a_q | b_q;
         default: alu_res_s = a_q;
      endcase
   end

   // Next-state: key decode per state, mode-edge clear, display selection.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      cnt_a_d = cnt_a_q;
      ovf_d   = ovf_q;
      neg_d   = neg_q;
      pulse_d = 1'b0;
      clr_s   = 1'b0;

      if (mode_edge_s) begin
         // A mode change wipes the transaction; a coincident key is dropped.
         clr_s = 1'b1;
      end else if (bus.key_strobe) begin
         if (key_is_digit_s) begin
            if (digit_ok_s) begin
               case (state_q)
                  ST_ENTER_A: begin
                     if (cnt_q != MAX_CNT) begin
                        a_d     = shift_in(a_q, digit_s, bus.dec_mode);
                        cnt_d   = cnt_q + 3'd1;
                        cnt_a_d = cnt_q + 3'd1;
                     end else begin
                        cnt_d = cnt_q;
                     end
                  end
                  ST_OP_SET, ST_ENTER_B: begin
                     if (cnt_q != MAX_CNT) begin
                        b_d     = shift_in(b_q, digit_s, bus.dec_mode);
                        cnt_d   = cnt_q + 3'd1;
                        state_d = ST_ENTER_B;
                     end else begin
                        cnt_d = cnt_q;
                     end
                  end
                  ST_RESULT: begin
                     a_d     = digit_w_s;
                     cnt_d   = 3'd1;
                     cnt_a_d = 3'd1;
                     ovf_d   = 1'b0;
                     neg_d   = 1'b0;
                     state_d = ST_ENTER_A;
                  end
                  default: state_d = ST_ENTER_A;
               endcase
            end else begin
               cnt_d = cnt_q;
            end
         end else if (key_op_s != OP_NONE) begin
            case (state_q)
               ST_ENTER_A: begin
                  op_d    = key_op_s;
                  b_d     = {W{1'b0}};
                  cnt_d   = 3'd0;
                  state_d = ST_OP_SET;
               end
               ST_OP_SET: op_d = key_op_s;
               ST_ENTER_B: begin
                  // Chain: fold the pending operation into A and start a new one.
                  res_d   = alu_res_s;
                  a_d     = alu_res_s;
                  b_d     = {W{1'b0}};
                  op_d    = key_op_s;
                  ovf_d   = alu_ovf_s;
                  neg_d   = alu_neg_s;
                  pulse_d = 1'b1;
                  cnt_d   = 3'd0;
                  cnt_a_d = 3'd0;   // a computed A has no typed digits
                  state_d = ST_OP_SET;
               end
               ST_RESULT: begin
                  a_d     = res_q;
                  b_d     = {W{1'b0}};
                  op_d    = key_op_s;
                  cnt_d   = 3'd0;
                  cnt_a_d = 3'd0;
                  state_d = ST_OP_SET;
               end
               default: state_d = ST_ENTER_A;
            endcase
         end else if (bus.key_val == KEY_EXE) begin
            case (state_q)
               ST_ENTER_B: begin
                  res_d   = alu_res_s;
                  ovf_d   = alu_ovf_s;
                  neg_d   = alu_neg_s;
                  pulse_d = 1'b1;
                  cnt_d   = 3'd0;
                  state_d = ST_RESULT;
               end
               ST_ENTER_A: begin
                  // No operation pending: A itself becomes the result.
                  res_d   = a_q;
                  ovf_d   = 1'b0;
                  neg_d   = 1'b0;
                  pulse_d = 1'b1;
                  cnt_d   = 3'd0;
                  state_d = ST_RESULT;
               end
               default: state_d = state_q;
            endcase
         end else if (bus.key_val == KEY_CE) begin
            case (state_q)
               ST_ENTER_A: begin
                  a_d     = {W{1'b0}};
                  cnt_d   = 3'd0;
                  cnt_a_d = 3'd0;
               end
               ST_ENTER_B: begin
                  b_d     = {W{1'b0}};
                  cnt_d   = 3'd0;
                  state_d = ST_OP_SET;
               end
               ST_OP_SET: begin
                  op_d    = OP_NONE;
                  cnt_d   = cnt_a_q;
                  state_d = ST_ENTER_A;
               end
               ST_RESULT: clr_s   = 1'b1;
               default:   state_d = ST_ENTER_A;
            endcase
         end else if (bus.key_val == KEY_CLR) begin
            clr_s = 1'b1;
         end else begin
            // Invalid codes leave everything untouched.
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end

      if (clr_s) begin
         state_d = ST_ENTER_A;
         a_d     = {W{1'b0}};
         b_d     = {W{1'b0}};
         res_d   = {W{1'b0}};
         op_d    = OP_NONE;
         cnt_d   = 3'd0;
         cnt_a_d = 3'd0;
         ovf_d   = 1'b0;
         neg_d   = 1'b0;
         pulse_d = 1'b0;
      end else begin
         pulse_d = pulse_d;
      end

      case (state_d)
         ST_ENTER_A, ST_OP_SET: disp_d = a_d;
         ST_ENTER_B:            disp_d = b_d;
         ST_RESULT:             disp_d = res_d;
         default:               disp_d = a_d;
      endcase
   end

   // State and output registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ENTER_A;
         a_q        <= {W{1'b0}};
         b_q        <= {W{1'b0}};
         res_q      <= {W{1'b0}};
         disp_q     <= {W{1'b0}};
         op_q       <= OP_NONE;
         cnt_q      <= 3'd0;
         cnt_a_q    <= 3'd0;
         ovf_q      <= 1'b0;
         neg_q      <= 1'b0;
         pulse_q    <= 1'b0;
         dec_q      <= 1'b0;
         mode_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         disp_q     <= disp_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         cnt_a_q    <= cnt_a_d;
         ovf_q      <= ovf_d;
         neg_q      <= neg_d;
         pulse_q    <= pulse_d;
         dec_q      <= bus.dec_mode;
         mode_vld_q <= 1'b1;
      end
   end

   assign bus.display_val  = disp_q;
   assign bus.state        = state_q;
   assign bus.op_sel       = op_q;
   assign bus.digit_cnt    = cnt_q;
   assign bus.overflow     = ovf_q;
   assign bus.negative     = neg_q;
   assign bus.result_pulse = pulse_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: each stimulus cycle queues the
// hand-computed outputs expected one cycle later; a monitor pops and compares.
module tb_calc_key_sequencer;

   typedef struct {
      string       name;
      logic [15:0] disp;
      logic [1:0]  st;
      logic [2:0]  op;
      logic [2:0]  cnt;
      logic        ovf;
      logic        neg;
      logic        pls;
   } exp_t;

   logic clk;
   logic rst;
   logic chk;
   int   n_assert;
   int   n_fail;
   exp_t sb_q[$];

   calc_key_sequencer_if #(.W(16)) bus ();

   calc_key_sequencer #(.W(16), .MAX_DIGITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of input and queue the outputs expected after the next edge.
   task automatic step(input logic stb, input logic [4:0] key, input logic mode,
                       input logic [15:0] d, input logic [1:0] s, input logic [2:0] o,
                       input logic [2:0] c, input logic ov, input logic ng,
                       input logic p, input string nm);
      exp_t e;
      @(negedge clk);
      bus.key_strobe = stb;
      bus.key_val    = key;
      bus.dec_mode   = mode;
      e.name = nm; e.disp = d; e.st = s; e.op = o; e.cnt = c;
      e.ovf = ov; e.neg = ng; e.pls = p;
      sb_q.push_back(e);
      chk = 1'b1;
   endtask

   // Quiet cycle with nothing queued.
   task automatic idle();
      @(negedge clk);
      bus.key_strobe = 1'b0;
      chk = 1'b0;
   endtask

   // Monitor: after each edge that a stimulus cycle produced, compare outputs.
   initial begin
      logic fire;
      exp_t e;
      forever begin
         @(posedge clk);
         fire = chk;
         #1;
         if (fire) begin
            n_assert++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_empty: got output cycle, required a queued expectation");
            end else begin
               e = sb_q.pop_front();
               if ({bus.display_val, bus.state, bus.op_sel, bus.digit_cnt,
                    bus.overflow, bus.negative, bus.result_pulse} !==
                   {e.disp, e.st, e.op, e.cnt, e.ovf, e.neg, e.pls}) begin
                  n_fail++;
                  $display("FAIL %s: got disp=%h st=%0d op=%0d cnt=%0d ovf=%b neg=%b pls=%b, required disp=%h st=%0d op=%0d cnt=%0d ovf=%b neg=%b pls=%b",
                           e.name, bus.display_val, bus.state, bus.op_sel, bus.digit_cnt,
                           bus.overflow, bus.negative, bus.result_pulse,
                           e.disp, e.st, e.op, e.cnt, e.ovf, e.neg, e.pls);
               end
            end
         end
      end
   end

   initial begin
      n_assert       = 0;
      n_fail         = 0;
      chk            = 1'b0;
      rst            = 1'b1;
      bus.key_strobe = 1'b0;
      bus.key_val    = 5'h00;
      bus.dec_mode   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      step(1'b0, 5'h00, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "reset_values");

      // Hex mode: A3 + 5
      step(1'b1, 5'h0A, 1'b0, 16'h000A, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "hex_digit_A");
      step(1'b1, 5'h03, 1'b0, 16'h00A3, 2'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, "hex_digit_3");
      step(1'b1, 5'h10, 1'b0, 16'h00A3, 2'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, "hex_add_key");
      step(1'b1, 5'h05, 1'b0, 16'h0005, 2'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, "hex_b_digit_5");
      step(1'b1, 5'h13, 1'b0, 16'h00A8, 2'd3, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, "hex_exe_a8");
      step(1'b0, 5'h00, 1'b0, 16'h00A8, 2'd3, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, "pulse_one_cycle");
      step(1'b1, 5'h1B, 1'b0, 16'h00A8, 2'd3, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, "invalid_1b");
      step(1'b1, 5'h17, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "clr_in_result");

      // Decimal mode: saturation, rejected digit, MUL overflow
      step(1'b0, 5'h00, 1'b1, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "mode_to_dec");
      step(1'b1, 5'h09, 1'b1, 16'd9,    2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "dec_a_9");
      step(1'b1, 5'h09, 1'b1, 16'd99,   2'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, "dec_a_99");
      step(1'b1, 5'h09, 1'b1, 16'd999,  2'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, "dec_a_999");
      step(1'b1, 5'h09, 1'b1, 16'd9999, 2'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, "dec_a_9999");
      step(1'b1, 5'h09, 1'b1, 16'd9999, 2'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, "dec_a_saturate");
      step(1'b1, 5'h11, 1'b1, 16'd9999, 2'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, "dec_mul_key");
      step(1'b1, 5'h0C, 1'b1, 16'd9999, 2'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, "dec_reject_c");
      step(1'b1, 5'h09, 1'b1, 16'd9,    2'd2, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, "dec_b_9");
      step(1'b1, 5'h09, 1'b1, 16'd99,   2'd2, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, "dec_b_99");
      step(1'b1, 5'h09, 1'b1, 16'd999,  2'd2, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, "dec_b_999");
      step(1'b1, 5'h09, 1'b1, 16'd9999, 2'd2, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, "dec_b_9999");
      // 9999*9999 = 99980001 = 0x05F5_92E1 -> low half 0x92E1, high half nonzero
      step(1'b1, 5'h13, 1'b1, 16'h92E1, 2'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, "dec_mul_ovf");
      step(1'b1, 5'h17, 1'b1, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "clr_after_mul");

      // Mode edge mid-entry drops the coincident digit and clears everything
      step(1'b1, 5'h01, 1'b1, 16'd1,    2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "dec_a_1");
      step(1'b1, 5'h02, 1'b1, 16'd12,   2'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, "dec_a_12");
      step(1'b1, 5'h03, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "mode_edge_clr");
      step(1'b0, 5'h00, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "after_mode_edge");

      // Hex SUB underflow, then ADD carry clears negative
      step(1'b1, 5'h03, 1'b0, 16'h0003, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "sub_a_3");
      step(1'b1, 5'h14, 1'b0, 16'h0003, 2'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, "sub_key");
      step(1'b1, 5'h05, 1'b0, 16'h0005, 2'd2, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, "sub_b_5");
      step(1'b1, 5'h13, 1'b0, 16'hFFFE, 2'd3, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, "sub_negative");
      step(1'b1, 5'h10, 1'b0, 16'hFFFE, 2'd1, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, "result_to_add");
      step(1'b1, 5'h02, 1'b0, 16'h0002, 2'd2, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0, "add_b_2");
      step(1'b1, 5'h13, 1'b0, 16'h0000, 2'd3, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, "add_carry");
      step(1'b1, 5'h17, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "clr_after_add");

      // Chaining and CE
      step(1'b1, 5'h02, 1'b0, 16'h0002, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "chain_a_2");
      step(1'b1, 5'h10, 1'b0, 16'h0002, 2'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, "chain_add");
      step(1'b1, 5'h03, 1'b0, 16'h0003, 2'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, "chain_b_3");
      step(1'b1, 5'h11, 1'b0, 16'h0005, 2'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, "chain_mul");
      step(1'b1, 5'h04, 1'b0, 16'h0004, 2'd2, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, "chain_b_4");
      step(1'b1, 5'h16, 1'b0, 16'h0005, 2'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, "ce_in_enter_b");
      step(1'b1, 5'h06, 1'b0, 16'h0006, 2'd2, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, "chain_b_6");
      step(1'b1, 5'h13, 1'b0, 16'h001E, 2'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, "chain_exe_30");
      step(1'b1, 5'h16, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "ce_in_result");

      // CE in OP_SET restores A's digit count
      step(1'b1, 5'h07, 1'b0, 16'h0007, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "ce_a_7");
      step(1'b1, 5'h12, 1'b0, 16'h0007, 2'd1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, "and_key");
      step(1'b1, 5'h16, 1'b0, 16'h0007, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "ce_in_op_set");

      // Async reset during ENTER_B
      step(1'b1, 5'h15, 1'b0, 16'h0007, 2'd1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, "or_key");
      step(1'b1, 5'h08, 1'b0, 16'h0008, 2'd2, 3'd5, 3'd1, 1'b0, 1'b0, 1'b0, "or_b_8");
      idle();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_assert++;
      if ({bus.display_val, bus.state, bus.op_sel, bus.digit_cnt,
           bus.overflow, bus.negative, bus.result_pulse} !== 31'd0) begin
         n_fail++;
         $display("FAIL async_reset: got disp=%h st=%0d op=%0d cnt=%0d, required all zero",
                  bus.display_val, bus.state, bus.op_sel, bus.digit_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'h00, 1'b0, 16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "post_rst_idle");
      step(1'b1, 5'h01, 1'b0, 16'h0001, 2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, "first_after_rst");
      idle();
      repeat (3) @(negedge clk);

      n_assert++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
